// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared constants and helpers for the USB receive path
// Purpose: default bit-stuffing threshold, idle (J) line level, and the
//          helper that sizes a run counter able to hold 0..n.
// Ports:   none (package)
package usb_rx_pkg;

  localparam int   STUFF_LEN_DEF = 6;
  localparam logic IDLE_J        = 1'b1;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ones_run_counter.sv
// rtl/ones_run_counter.sv - run-length counter of consecutive decoded ones
// Purpose: counts consecutive 1s in the decoded stream and saturates at MAX.
//          The slot after MAX ones is the stuff slot: it always returns the
//          count to zero, whatever the bit value.
// Ports:
//   clk     in  system clock
//   n_rst   in  asynchronous active-low reset
//   clr     in  synchronous clear (priority over en)
//   en      in  a bit is being consumed this cycle
//   bit_in  in  value of the consumed decoded bit
//   cnt     out current run of ones (W bits)
//   at_max  out cnt == MAX, i.e. the next consumed bit is a stuff bit
module ones_run_counter
  import usb_rx_pkg::*;
#(
  parameter  int MAX = STUFF_LEN_DEF,
  localparam int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  assign at_max = (cnt == MAX_C);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      // Incrementing only below MAX keeps the count saturating without wrap.
      if (at_max || !bit_in) cnt <= '0;
      else                   cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/nrzi_unstuff_decode.sv
// rtl/nrzi_unstuff_decode.sv - USB receive NRZI decoder and bit unstuffer
// Purpose: per shift_enable strobe, decodes the sampled D+ level (NRZI or
//          pass-through), drops stuffed bits, flags stuff violations, and
//          presents qualified bits to the RX shift register.
// Ports:
//   clk          in  system clock
//   n_rst        in  asynchronous active-low reset
//   d_plus       in  synchronised D+ line sample
//   shift_enable in  sample d_plus as the next bit this cycle
//   eop          in  end-of-packet seen; qualifies shift_enable
//   clear        in  synchronous abort back to idle (highest priority)
//   d_orig       out last accepted decoded bit
//   bit_valid    out one-cycle pulse: d_orig holds a new data bit
//   stuff_err    out one-cycle pulse: stuff slot carried a 1
//   ones_cnt     out current run of decoded ones
module nrzi_unstuff_decode
  import usb_rx_pkg::*;
#(
  parameter  int   STUFF_LEN  = STUFF_LEN_DEF,
  parameter  logic IDLE_LEVEL = IDLE_J,
  parameter  bit   NRZI_EN    = 1'b1,
  localparam int   CW         = cnt_w(STUFF_LEN)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          d_plus,
  input  logic          shift_enable,
  input  logic          eop,
  input  logic          clear,
  output logic          d_orig,
  output logic          bit_valid,
  output logic          stuff_err,
  output logic [CW-1:0] ones_cnt
);

  logic prev;
  logic dec_bit;
  logic pkt_end;
  logic stuff_slot;

  // NRZI: no transition means 1, a transition means 0.
  assign dec_bit = NRZI_EN ? ~(prev ^ d_plus) : d_plus;
  assign pkt_end = eop & shift_enable;

  ones_run_counter #(
    .MAX (STUFF_LEN)
  ) u_ones (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (clear | pkt_end),
    .en     (shift_enable),
    .bit_in (dec_bit),
    .cnt    (ones_cnt),
    .at_max (stuff_slot)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev      <= IDLE_LEVEL;
      d_orig    <= 1'b1;
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;
      if (clear || pkt_end) begin
        // Next packet's first bit decodes against the idle level.
        prev <= IDLE_LEVEL;
      end else if (shift_enable) begin
        prev <= d_plus;
        if (stuff_slot) begin
          // Stuff bit is never forwarded; a 1 here is a protocol violation.
          stuff_err <= dec_bit;
        end else begin
          d_orig    <= dec_bit;
          bit_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nrzi_unstuff_decode.sv
// tb/tb_nrzi_unstuff_decode.sv - bench for nrzi_unstuff_decode
module tb_nrzi_unstuff_decode;

  typedef struct {
    bit sel;
    bit se, eop, clr, dp;
    bit ed, ev, ee;
    int ec;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  logic dp1 = 1'b0, se1 = 1'b0, eop1 = 1'b0, clr1 = 1'b0;
  logic d1, v1, e1;
  logic [2:0] c1;

  logic dp2 = 1'b0, se2 = 1'b0, eop2 = 1'b0, clr2 = 1'b0;
  logic d2, v2, e2;
  logic [1:0] c2;

  int checks = 0;
  int errors = 0;

  vec_t vec_a[$];
  vec_t vec_b[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  nrzi_unstuff_decode dut (
    .clk(clk), .n_rst(n_rst), .d_plus(dp1), .shift_enable(se1), .eop(eop1),
    .clear(clr1), .d_orig(d1), .bit_valid(v1), .stuff_err(e1), .ones_cnt(c1)
  );

  nrzi_unstuff_decode #(.STUFF_LEN(3), .NRZI_EN(1'b0)) dut_raw (
    .clk(clk), .n_rst(n_rst), .d_plus(dp2), .shift_enable(se2), .eop(eop2),
    .clear(clr2), .d_orig(d2), .bit_valid(v2), .stuff_err(e2), .ones_cnt(c2)
  );

  function automatic vec_t mk(bit sel, bit se, bit eop, bit clr, bit dp,
                              bit ed, bit ev, bit ee, int ec);
    vec_t v;
    v.sel = sel; v.se = se; v.eop = eop; v.clr = clr; v.dp = dp;
    v.ed = ed; v.ev = ev; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    if (v.sel) begin
      dp2 = v.dp; se2 = v.se; eop2 = v.eop; clr2 = v.clr;
      se1 = 1'b0; eop1 = 1'b0; clr1 = 1'b0;
    end else begin
      dp1 = v.dp; se1 = v.se; eop1 = v.eop; clr1 = v.clr;
      se2 = 1'b0; eop2 = 1'b0; clr2 = 1'b0;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.sel) begin
      chk({tag, ".d_orig"}, int'(d2), int'(e.ed));
      chk({tag, ".bit_valid"}, int'(v2), int'(e.ev));
      chk({tag, ".stuff_err"}, int'(e2), int'(e.ee));
      chk({tag, ".ones_cnt"}, int'(c2), e.ec);
    end else begin
      chk({tag, ".d_orig"}, int'(d1), int'(e.ed));
      chk({tag, ".bit_valid"}, int'(v1), int'(e.ev));
      chk({tag, ".stuff_err"}, int'(e1), int'(e.ee));
      chk({tag, ".ones_cnt"}, int'(c1), e.ec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: idle J held -> decoded ones
    for (int k = 1; k <= 3; k++) vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,k));
    vec_a.push_back(mk(0, 0,0,0,1, 1,0,0,3));
    // 2: line 1,0,1,1 -> 1,0,0,1
    vec_a.push_back(mk(0, 0,0,1,1, 1,0,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,1));
    vec_a.push_back(mk(0, 1,0,0,0, 0,1,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 0,1,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,1));
    // 3: six ones, stuffed 0 dropped, then a transition decodes as 0
    vec_a.push_back(mk(0, 0,0,1,1, 1,0,0,0));
    for (int k = 1; k <= 6; k++) vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,k));
    vec_a.push_back(mk(0, 1,0,0,0, 1,0,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 0,1,0,0));
    // 4: seventh one is a stuff violation
    vec_a.push_back(mk(0, 0,0,1,1, 0,0,0,0));
    for (int k = 1; k <= 6; k++) vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,k));
    vec_a.push_back(mk(0, 1,0,0,1, 1,0,1,0));
    vec_a.push_back(mk(0, 0,0,0,1, 1,0,0,0));
    // 5: eop with run of 4, prev reloaded to J
    vec_a.push_back(mk(0, 0,0,1,1, 1,0,0,0));
    for (int k = 1; k <= 4; k++) vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,k));
    vec_a.push_back(mk(0, 1,1,0,0, 1,0,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,1));
    // 6: clear beats shift_enable, prev reloaded to J
    vec_a.push_back(mk(0, 1,0,0,0, 0,1,0,0));
    vec_a.push_back(mk(0, 1,0,0,0, 1,1,0,1));
    vec_a.push_back(mk(0, 1,0,0,0, 1,1,0,2));
    vec_a.push_back(mk(0, 1,0,1,0, 1,0,0,0));
    vec_a.push_back(mk(0, 1,0,0,1, 1,1,0,1));
    vec_a.push_back(mk(0, 1,0,0,0, 0,1,0,0));
    // after async reset: first bit decodes against J
    vec_b.push_back(mk(0, 1,0,0,1, 1,1,0,1));
    // 7: pass-through build, STUFF_LEN 3
    for (int k = 1; k <= 3; k++) vec_b.push_back(mk(1, 1,0,0,1, 1,1,0,k));
    vec_b.push_back(mk(1, 1,0,0,0, 1,0,0,0));
    vec_b.push_back(mk(1, 1,0,0,1, 1,1,0,1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.d_orig", int'(d1), 1);
    chk("rst.bit_valid", int'(v1), 0);
    chk("rst.stuff_err", int'(e1), 0);
    chk("rst.ones_cnt", int'(c1), 0);
    chk("rst_raw.ones_cnt", int'(c2), 0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vec_a[i]) apply(vec_a[i], $sformatf("a%0d", i));

    // Async reset mid-run while bit_valid is high and d_orig is 0.
    #1;
    se1 = 1'b0; clr1 = 1'b0; eop1 = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("arst.d_orig", int'(d1), 1);
    chk("arst.bit_valid", int'(v1), 0);
    chk("arst.stuff_err", int'(e1), 0);
    chk("arst.ones_cnt", int'(c1), 0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vec_b[i]) apply(vec_b[i], $sformatf("b%0d", i));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
